vrf_operand_requester: RTL and testbench

Lane-level initiator for the banked vector register file. It turns per-operand-queue read commands (start word address and word count) and a single write stream into per-bank SRAM requests: `req`, `addr`, `wen`, `wdata`, `be` and `tgt_opqueue`. It sits between the lane sequencer and the VRF. Read issue is throttled by per-queue credits, so no operand queue can overflow.

---
 rtl/vrf_operand_requester_pkg.sv | 25 ++
 rtl/vrf_operand_requester_read_sequencer.sv | 105 ++++++++++
 rtl/vrf_operand_requester.sv | 166 ++++++++++++++++
 tb/tb_vrf_operand_requester.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_operand_requester_pkg.sv
// Shared types for the VRF operand requester slice.
// Provides the element/strobe types, the operand-queue enumeration and the
// read-sequencer state encoding used by vrf_read_sequencer and
// vrf_operand_requester.
package vrf_operand_requester_pkg;

  localparam int unsigned ELEN            = 64;
  localparam int unsigned NrOperandQueues = 4;

  typedef logic [ELEN-1:0]   elen_t;
  typedef logic [ELEN/8-1:0] strb_t;

  // One entry per operand queue fed by the VRF.
  typedef enum logic [1:0] {
    ALU_A  = 2'd0,
    ALU_B  = 2'd1,
    MFPU_A = 2'd2,
    MFPU_B = 2'd3
  } opqueue_e;

  // Read-sequencer states.
  localparam logic [0:0] SEQ_IDLE = 1'b0;
  localparam logic [0:0] SEQ_REQ  = 1'b1;

endpackage

// File: rtl/vrf_operand_requester_read_sequencer.sv
// vrf_read_sequencer: per-operand-queue read command walker.
// Accepts a (start address, length) command, then raises rd_req once per word
// while the queue has credit. Each grant advances the address (wrapping at the
// end of the VRF), consumes one credit and one remaining word. Pops from the
// operand queue return credits. done pulses the cycle after the last grant or
// after a zero-length command is accepted.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_addr, cmd_len       start word address and word count
//   pop                     operand queue consumed one word (credit return)
//   grant                   this queue's request won its bank this cycle
//   rd_req, rd_addr         outstanding request and its VRF word address
//   done                    one-cycle completion pulse
module vrf_read_sequencer
  import vrf_operand_requester_pkg::*;
#(
  parameter type         vaddr_t    = logic [6:0],
  parameter int unsigned TotWords   = 128,
  parameter int unsigned LenWidth   = 8,
  parameter int unsigned QueueDepth = 2,
  localparam int unsigned CreditW   = $clog2(QueueDepth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  vaddr_t              cmd_addr,
  input  logic [LenWidth-1:0] cmd_len,
  input  logic                pop,
  input  logic                grant,
  output logic                rd_req,
  output vaddr_t              rd_addr,
  output logic                done
);

  localparam vaddr_t               LastAddr   = vaddr_t'(TotWords - 1);
  localparam logic [CreditW-1:0]   CreditInit = CreditW'(QueueDepth);

  logic [0:0]          state_reg;
  vaddr_t              addr_reg;
  logic [LenWidth-1:0] rem_reg;
  logic [CreditW-1:0]  credit_reg;
  logic [CreditW-1:0]  credit_next;
  logic                done_reg;

  assign cmd_ready = (state_reg == SEQ_IDLE);
  assign rd_req    = (state_reg == SEQ_REQ) && (credit_reg != '0);
  assign rd_addr   = addr_reg;
  assign done      = done_reg;

  // A pop and a grant in the same cycle cancel out.
  always_comb begin
    credit_next = credit_reg;
    if (pop && !grant) begin
      credit_next = credit_reg + CreditW'(1);
    end else if (!pop && grant) begin
      credit_next = credit_reg - CreditW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= SEQ_IDLE;
      addr_reg   <= '0;
      rem_reg    <= '0;
      credit_reg <= CreditInit;
      done_reg   <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      done_reg   <= 1'b0;
      case (state_reg)
        SEQ_IDLE: begin
          if (cmd_valid) begin
            addr_reg <= cmd_addr;
            rem_reg  <= cmd_len;
            // Zero-length commands complete without touching the VRF.
            if (cmd_len == '0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= SEQ_REQ;
            end
          end
        end
        SEQ_REQ: begin
          if (grant) begin
            addr_reg <= (addr_reg == LastAddr) ? '0 : addr_reg + vaddr_t'(1);
            rem_reg  <= rem_reg - LenWidth'(1);
            if (rem_reg == LenWidth'(1)) begin
              state_reg <= SEQ_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= SEQ_IDLE;
      endcase
    end
  end

  // Returning a credit to a full counter means the queue popped a word it
  // never asked for.
  pop_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && !grant && (credit_reg == CreditInit)));

endmodule

// File: rtl/vrf_operand_requester.sv
// vrf_operand_requester: lane-level VRF initiator.
// One vrf_read_sequencer per operand queue produces read requests; each bank
// then picks a winner: a write to the bank always wins, otherwise the
// requesting queues are served round-robin. Bank outputs are combinational
// from the sequencer registers and the write inputs.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o            per-queue read command handshake
//   cmd_addr_i, cmd_len_i              start word address, word count
//   done_o                             per-queue completion pulse
//   opqueue_pop_i                      per-queue credit return
//   wr_valid_i/wr_ready_o              write stream (always ready)
//   wr_addr_i, wr_data_i, wr_be_i      write address, data, byte enables
//   req_o, addr_o, wen_o, wdata_o,
//   be_o, tgt_opqueue_o                per-bank SRAM request
module vrf_operand_requester
  import vrf_operand_requester_pkg::*;
#(
  parameter int unsigned  NrBanks    = 8,
  parameter int unsigned  VRFSize    = 8192,
  parameter type          vaddr_t    = logic [6:0],
  parameter int unsigned  QueueDepth = 2,
  localparam int unsigned NumWords   = VRFSize / NrBanks / $bits(elen_t),
  localparam int unsigned TotWords   = NumWords * NrBanks,
  localparam int unsigned LenWidth   = $clog2(TotWords) + 1,
  localparam int unsigned BankIdxW   = $clog2(NrBanks)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic     [NrOperandQueues-1:0]           cmd_valid_i,
  output logic     [NrOperandQueues-1:0]           cmd_ready_o,
  input  vaddr_t   [NrOperandQueues-1:0]           cmd_addr_i,
  input  logic     [NrOperandQueues-1:0][LenWidth-1:0] cmd_len_i,
  output logic     [NrOperandQueues-1:0]           done_o,
  input  logic     [NrOperandQueues-1:0]           opqueue_pop_i,
  input  logic                                     wr_valid_i,
  output logic                                     wr_ready_o,
  input  vaddr_t                                   wr_addr_i,
  input  elen_t                                    wr_data_i,
  input  strb_t                                    wr_be_i,
  output logic     [NrBanks-1:0]                   req_o,
  output vaddr_t   [NrBanks-1:0]                   addr_o,
  output opqueue_e [NrBanks-1:0]                   tgt_opqueue_o,
  output logic     [NrBanks-1:0]                   wen_o,
  output elen_t    [NrBanks-1:0]                   wdata_o,
  output strb_t    [NrBanks-1:0]                   be_o
);

  localparam int unsigned      QIdxW = $clog2(NrOperandQueues);
  localparam logic [QIdxW-1:0] LastQ = QIdxW'(NrOperandQueues - 1);

  logic   [NrOperandQueues-1:0]              rd_req;
  vaddr_t [NrOperandQueues-1:0]              rd_addr;
  logic   [NrOperandQueues-1:0]              grant;
  logic   [NrBanks-1:0][NrOperandQueues-1:0] bank_grant;

  assign wr_ready_o = 1'b1;

  for (genvar gi = 0; gi < NrOperandQueues; gi++) begin : gen_seq
    vrf_read_sequencer #(
      .vaddr_t    (vaddr_t),
      .TotWords   (TotWords),
      .LenWidth   (LenWidth),
      .QueueDepth (QueueDepth)
    ) i_seq (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cmd_valid (cmd_valid_i[gi]),
      .cmd_ready (cmd_ready_o[gi]),
      .cmd_addr  (cmd_addr_i[gi]),
      .cmd_len   (cmd_len_i[gi]),
      .pop       (opqueue_pop_i[gi]),
      .grant     (grant[gi]),
      .rd_req    (rd_req[gi]),
      .rd_addr   (rd_addr[gi]),
      .done      (done_o[gi])
    );
  end

  // Each queue addresses exactly one bank per cycle, so OR-ing the per-bank
  // grant vectors never merges two grants for the same queue.
  always_comb begin
    grant = '0;
    for (int b = 0; b < NrBanks; b++) begin
      grant = grant | bank_grant[b];
    end
  end

  for (genvar gi = 0; gi < NrBanks; gi++) begin : gen_bank
    logic [QIdxW-1:0]           rr_ptr_reg;
    logic [NrOperandQueues-1:0] bank_req;
    logic                       wr_hit;
    logic                       rd_win;
    logic [QIdxW-1:0]           winner;
    logic [QIdxW-1:0]           cand;
    logic                       read_grant;
    logic                       b_req;
    logic                       b_wen;
    vaddr_t                     b_addr;
    opqueue_e                   b_tgt;
    elen_t                      b_wdata;
    strb_t                      b_be;

    always_comb begin
      for (int q = 0; q < NrOperandQueues; q++) begin
        bank_req[q] = rd_req[q] && (rd_addr[q][BankIdxW-1:0] == BankIdxW'(gi));
      end
    end

    assign wr_hit = wr_valid_i && (wr_addr_i[BankIdxW-1:0] == BankIdxW'(gi));

    // Round-robin search starting at the pointer.
    always_comb begin
      rd_win = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NrOperandQueues; k++) begin
        cand = QIdxW'((int'(rr_ptr_reg) + k) % NrOperandQueues);
        if (!rd_win && bank_req[cand]) begin
          rd_win = 1'b1;
          winner = cand;
        end
      end
    end

    assign read_grant     = rd_win && !wr_hit;
    assign bank_grant[gi] = NrOperandQueues'(read_grant) << winner;

    // The pointer only moves when a read actually gets the bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_ptr_reg <= '0;
      end else if (read_grant) begin
        rr_ptr_reg <= (winner == LastQ) ? '0 : winner + QIdxW'(1);
      end
    end

    always_comb begin
      b_req   = 1'b0;
      b_wen   = 1'b0;
      b_addr  = '0;
      b_tgt   = ALU_A;
      b_wdata = '0;
      b_be    = '0;
      if (wr_hit) begin
        b_req   = 1'b1;
        b_wen   = 1'b1;
        b_addr  = wr_addr_i >> BankIdxW;
        b_wdata = wr_data_i;
        b_be    = wr_be_i;
      end else if (rd_win) begin
        b_req  = 1'b1;
        b_addr = rd_addr[winner] >> BankIdxW;
        b_tgt  = opqueue_e'(winner);
      end
    end

    assign req_o[gi]         = b_req;
    assign wen_o[gi]         = b_wen;
    assign addr_o[gi]        = b_addr;
    assign tgt_opqueue_o[gi] = b_tgt;
    assign wdata_o[gi]       = b_wdata;
    assign be_o[gi]          = b_be;
  end

endmodule

// File: tb/tb_vrf_operand_requester.sv
module tb_vrf_operand_requester;
  import vrf_operand_requester_pkg::*;

  localparam int NB = 8;
  localparam int NQ = NrOperandQueues;
  localparam int QD = 2;
  localparam int TW = 128;
  localparam int LW = 8;

  typedef logic [6:0] va_t;

  logic clk = 1'b0;
  logic rst_n;
  logic     [NQ-1:0]         cmd_valid, cmd_ready, done, pop;
  va_t      [NQ-1:0]         cmd_addr;
  logic     [NQ-1:0][LW-1:0] cmd_len;
  logic                      wr_valid, wr_ready;
  va_t                       wr_addr;
  elen_t                     wr_data;
  strb_t                     wr_be;
  logic     [NB-1:0]         req, wen;
  va_t      [NB-1:0]         addr;
  opqueue_e [NB-1:0]         tgt;
  elen_t    [NB-1:0]         wdata;
  strb_t    [NB-1:0]         be;

  always #5 clk = ~clk;

  vrf_operand_requester #(
    .NrBanks    (NB),
    .VRFSize    (8192),
    .vaddr_t    (va_t),
    .QueueDepth (QD)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_addr_i    (cmd_addr),
    .cmd_len_i     (cmd_len),
    .done_o        (done),
    .opqueue_pop_i (pop),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_be_i       (wr_be),
    .req_o         (req),
    .addr_o        (addr),
    .tgt_opqueue_o (tgt),
    .wen_o         (wen),
    .wdata_o       (wdata),
    .be_o          (be)
  );

  // Reference model: per-queue list of words still to read, credits, and a
  // per-bank round-robin pointer.
  int m_busy[NQ], m_addr[NQ], m_rem[NQ], m_credit[NQ], m_done[NQ];
  int m_ptr[NB];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [NQ-1:0] auto_pop;
  int rand_pop;
  int req_tally;
  int b3_log[$];

  logic     [NB-1:0] o_req, o_wen;
  va_t      [NB-1:0] o_addr;
  opqueue_e [NB-1:0] o_tgt;
  logic     [NQ-1:0] o_done;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < NQ; q++) begin
      m_busy[q] = 0; m_addr[q] = 0; m_rem[q] = 0; m_credit[q] = QD; m_done[q] = 0;
    end
    for (int b = 0; b < NB; b++) m_ptr[b] = 0;
  endtask

  task automatic cmd(input int q, input int a, input int l);
    cmd_valid[q] = 1'b1;
    cmd_addr[q]  = va_t'(a);
    cmd_len[q]   = 8'(l);
  endtask

  // Called just after a rising edge with inputs set; checks this cycle's
  // outputs against the model, advances the model, moves to the next cycle.
  task automatic cycle();
    logic     [NB-1:0] e_req, e_wen;
    va_t      [NB-1:0] e_addr;
    opqueue_e [NB-1:0] e_tgt;
    elen_t    [NB-1:0] e_wdata;
    strb_t    [NB-1:0] e_be;
    logic     [NQ-1:0] e_ready, e_done, gnt;
    int wbank, q, found;
    for (int i = 0; i < NQ; i++)
      pop[i] = (m_credit[i] < QD) && (auto_pop[i] || ($urandom_range(0, 99) < rand_pop));
    #1;
    e_req = '0; e_wen = '0; e_addr = '0; e_wdata = '0; e_be = '0; gnt = '0;
    for (int b = 0; b < NB; b++) e_tgt[b] = ALU_A;
    wbank = wr_valid ? int'(wr_addr) % NB : -1;
    for (int b = 0; b < NB; b++) begin
      if (b == wbank) begin
        e_req[b] = 1'b1; e_wen[b] = 1'b1;
        e_addr[b] = va_t'(int'(wr_addr) / NB);
        e_wdata[b] = wr_data; e_be[b] = wr_be;
      end else begin
        found = 0;
        for (int k = 0; k < NQ; k++) begin
          q = (m_ptr[b] + k) % NQ;
          if (found == 0 && m_busy[q] != 0 && m_credit[q] > 0 && m_addr[q] % NB == b) begin
            found = 1;
            e_req[b] = 1'b1;
            e_addr[b] = va_t'(m_addr[q] / NB);
            e_tgt[b] = opqueue_e'(q);
            gnt[q] = 1'b1;
            m_ptr[b] = (q + 1) % NQ;
          end
        end
      end
    end
    for (int i = 0; i < NQ; i++) begin
      e_ready[i] = (m_busy[i] == 0);
      e_done[i]  = (m_done[i] != 0);
    end
    chk("req", 1024'(req), 1024'(e_req));
    chk("wen", 1024'(wen), 1024'(e_wen));
    chk("addr", 1024'(addr), 1024'(e_addr));
    chk("tgt", 1024'(tgt), 1024'(e_tgt));
    chk("wdata", 1024'(wdata), 1024'(e_wdata));
    chk("be", 1024'(be), 1024'(e_be));
    chk("done", 1024'(done), 1024'(e_done));
    chk("cmd_ready", 1024'(cmd_ready), 1024'(e_ready));
    chk("wr_ready", 1024'(wr_ready), 1024'(1));
    $display("cyc %0d cmd_v=%b req=%b wen=%b done=%b pop=%b", cyc, cmd_valid, req, wen, done, pop);
    o_req = req; o_wen = wen; o_addr = addr; o_tgt = tgt; o_done = done;
    req_tally += $countones(req & ~wen);
    if (req[3] && !wen[3]) b3_log.push_back(int'(tgt[3]));
    for (int i = 0; i < NQ; i++) begin
      int dn;
      dn = 0;
      if (m_busy[i] == 0 && cmd_valid[i]) begin
        if (cmd_len[i] == '0) dn = 1;
        else begin
          m_busy[i] = 1; m_addr[i] = int'(cmd_addr[i]); m_rem[i] = int'(cmd_len[i]);
        end
      end else if (gnt[i]) begin
        m_addr[i] = (m_addr[i] + 1) % TW;
        m_rem[i]--;
        if (m_rem[i] == 0) begin m_busy[i] = 0; dn = 1; end
      end
      m_credit[i] = m_credit[i] + int'(pop[i]) - int'(gnt[i]);
      m_done[i] = dn;
    end
    @(posedge clk);
    #1;
    cyc++;
    cmd_valid = '0;
    wr_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = '0; cmd_addr = '0; cmd_len = '0; pop = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    auto_pop = '0; rand_pop = 0; req_tally = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 1024'(cmd_ready), 1024'(4'hF));
    chk("rst_req", 1024'(req), 1024'(0));
    chk("rst_done", 1024'(done), 1024'(0));
    chk("rst_addr", 1024'(addr), 1024'(0));
    chk("rst_wr_ready", 1024'(wr_ready), 1024'(1));
    rst_n = 1'b1;

    // Streaming read, queue 0, 5..7, pops keep credits topped up.
    auto_pop = 4'b0001;
    cmd(0, 5, 3); cycle();
    cycle(); chk("s1_req5", 1024'(o_req), 1024'(8'h20));
    chk("s1_addr5", 1024'(o_addr[5]), 1024'(0));
    chk("s1_tgt5", 1024'(o_tgt[5]), 1024'(ALU_A));
    cycle(); chk("s1_req6", 1024'(o_req), 1024'(8'h40));
    cycle(); chk("s1_req7", 1024'(o_req), 1024'(8'h80));
    cycle(); chk("s1_done", 1024'(o_done), 1024'(4'b0001));
    auto_pop = '0;

    // Credit throttling: no pops lets only QueueDepth words out.
    req_tally = 0;
    cmd(1, 16, 4); cycle();
    repeat (5) cycle();
    chk("s2_two_reqs", 1024'(req_tally), 1024'(2));
    auto_pop = 4'b0010; cycle(); auto_pop = '0;
    req_tally = 0;
    repeat (3) cycle();
    chk("s2_one_more", 1024'(req_tally), 1024'(1));
    auto_pop = 4'b0010; repeat (4) cycle(); auto_pop = '0;

    // Bank-3 contention between queues 0 and 1.
    b3_log.delete();
    cmd(0, 3, 1); cmd(1, 11, 1); cycle();
    cycle(); cycle();
    cmd(0, 3, 1); cmd(1, 11, 1); cycle();
    cycle(); cycle(); cycle();
    chk("s3_count", 1024'(b3_log.size()), 1024'(4));
    for (int i = 0; i < 4; i++)
      if (i < b3_log.size()) chk("s3_order", 1024'(b3_log[i]), 1024'(i % 2));
    auto_pop = 4'b0011; repeat (3) cycle(); auto_pop = '0;

    // Write blocks the read to the same bank for one cycle.
    cmd(0, 3, 1); cycle();
    wr_valid = 1'b1; wr_addr = va_t'(11); wr_data = {$urandom, $urandom}; wr_be = 8'hA5;
    cycle();
    chk("s4_wen", 1024'(o_wen[3]), 1024'(1));
    chk("s4_waddr", 1024'(o_addr[3]), 1024'(1));
    cycle();
    chk("s4_rd_req", 1024'({o_req[3], o_wen[3]}), 1024'(2'b10));
    chk("s4_rd_tgt", 1024'(o_tgt[3]), 1024'(ALU_A));
    cycle();
    auto_pop = 4'b0001; repeat (2) cycle(); auto_pop = '0;

    // Address wrap 127 -> 0.
    cmd(2, 127, 2); cycle();
    cycle();
    chk("s5_req7", 1024'(o_req), 1024'(8'h80));
    chk("s5_addr7", 1024'(o_addr[7]), 1024'(15));
    chk("s5_tgt7", 1024'(o_tgt[7]), 1024'(MFPU_A));
    cycle();
    chk("s5_req0", 1024'(o_req), 1024'(8'h01));
    chk("s5_addr0", 1024'(o_addr[0]), 1024'(0));
    cycle();
    auto_pop = 4'b0100; repeat (2) cycle(); auto_pop = '0;

    // Zero-length command, then reset in the middle of a long read.
    cmd(3, 9, 0); cycle();
    cycle();
    chk("s6_done0", 1024'(o_done), 1024'(4'b1000));
    chk("s6_noreq", 1024'(o_req), 1024'(0));
    cmd(2, 40, 10); cycle();
    cycle(); cycle();
    rst_n = 1'b0;
    #1;
    chk("s6_rst_req", 1024'(req), 1024'(0));
    chk("s6_rst_ready", 1024'(cmd_ready), 1024'(4'hF));
    chk("s6_rst_done", 1024'(done), 1024'(0));
    chk("s6_rst_tgt", 1024'(tgt), 1024'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_tally = 0;
    cmd(2, 40, 4); cycle();
    repeat (4) cycle();
    chk("s6_credit_reset", 1024'(req_tally), 1024'(2));
    auto_pop = 4'b0100; repeat (6) cycle(); auto_pop = '0;

    // Randomized traffic against the model.
    rand_pop = 50;
    repeat (400) begin
      for (int q = 0; q < NQ; q++)
        if ($urandom_range(0, 99) < 30) cmd(q, $urandom_range(0, TW - 1), $urandom_range(0, 6));
      if ($urandom_range(0, 99) < 30) begin
        wr_valid = 1'b1;
        wr_addr  = va_t'($urandom_range(0, TW - 1));
        wr_data  = {$urandom, $urandom};
        wr_be    = strb_t'($urandom);
      end
      cycle();
    end
    repeat (40) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
